// File: rtl/long_multiplier_pkg.sv
// long_multiplier shared types and constants.
// State encodings and the step-count reload value.
package long_multiplier_pkg;

   localparam int N    = 8;
   localparam int LOGN = 3;

   typedef enum logic [1:0] {
      S1 = 2'b00,
      S2 = 2'b01,
      S3 = 2'b10
   } state_t;

   localparam logic [LOGN-1:0] CNT_LOAD = LOGN'(N - 1);

endpackage

// File: rtl/long_multiplier_if.sv
// long_multiplier start/acknowledge and operand bus.
// The master drives operands and s; the slave returns P and Done.
interface long_multiplier_if;
   import long_multiplier_pkg::*;

   logic           s;
   logic           LA;
   logic           EB;
   logic           EC;
   logic [N-1:0]   DataA;
   logic [N-1:0]   DataB;
   logic [N-1:0]   DataC;
   logic [2*N-1:0] P;
   logic           Done;

   modport master (
      output s, LA, EB, EC, DataA, DataB, DataC,
      input  P, Done
   );

   modport slave (
      input  s, LA, EB, EC, DataA, DataB, DataC,
      output P, Done
   );

endinterface

// File: rtl/long_multiplier_acc.sv
// long_multiplier_acc: 2n-bit product/accumulator register.
// Loads {hi, lo}, or adds b to the upper half and shifts right.
module long_multiplier_acc
   import long_multiplier_pkg::*;
(
   input  logic           Clock,
   input  logic           Resetn,
   input  logic           ld,
   input  logic           step,
   input  logic [N-1:0]   hi,
   input  logic [N-1:0]   lo,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   logic [N:0] sum;

   // upper half plus b when the current multiplier bit is set
   always_comb begin
      sum = {1'b0, p[2*N-1:N]};
      if (p[0]) sum = sum + {1'b0, b};
   end

   // load, shift-add step, or hold
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)   p <= '0;
      else if (ld)   p <= {hi, lo};
      else if (step) p <= {sum, p[N-1:1]};
   end

endmodule

// File: rtl/regne.sv
// regne: n-bit register with load enable.
// Asynchronous active-low clear.
module regne #(
   parameter int n = 8
) (
   input  logic [n-1:0] R,
   input  logic         Clock,
   input  logic         Resetn,
   input  logic         E,
   output logic [n-1:0] Q
);

   // capture R when enabled
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) Q <= '0;
      else if (E)  Q <= R;
   end

endmodule

// File: rtl/long_multiplier.sv
// long_multiplier: shift-and-add P = A*B + C, one bit per clock.
// Optional LONG_MULTIPLIER_ZERO_SKIP_EN: finish at once on a zero operand.
module long_multiplier
   import long_multiplier_pkg::*;
(
   input  logic             Clock,
   input  logic             Resetn,
   long_multiplier_if.slave bus
);

   state_t          state;
   state_t          nstate;
   logic [LOGN-1:0] count;
   logic [N-1:0]    a;
   logic [N-1:0]    b;
   logic [N-1:0]    c;
   logic [N-1:0]    hi;
   logic [N-1:0]    lo;
   logic            idle;
   logic            busy;

   assign idle = (state == S1);
   assign busy = (state == S2);

   regne #(.n(N)) ra (
      .R(bus.DataA), .Clock(Clock), .Resetn(Resetn),
      .E(bus.LA & idle), .Q(a)
   );

   regne #(.n(N)) rb (
      .R(bus.DataB), .Clock(Clock), .Resetn(Resetn),
      .E(bus.EB & idle), .Q(b)
   );

   regne #(.n(N)) rc (
      .R(bus.DataC), .Clock(Clock), .Resetn(Resetn),
      .E(bus.EC & idle), .Q(c)
   );

`ifdef LONG_MULTIPLIER_ZERO_SKIP_EN
   logic skip;

   assign skip = idle & bus.s & ((a == '0) | (b == '0));
   assign hi   = skip ? '0 : c;
   assign lo   = skip ? c : a;
`else
   assign hi = c;
   assign lo = a;
`endif

   // state register
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state <= S1;
      else         state <= nstate;
   end

   // step counter: reload while idle, count down while stepping
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)   count <= '0;
      else if (idle) count <= CNT_LOAD;
      else if (busy) count <= count - LOGN'(1);
   end

   // next-state logic
   always_comb begin
      nstate = S1;
      case (state)
         S1: begin
            if (bus.s) begin
`ifdef LONG_MULTIPLIER_ZERO_SKIP_EN
               nstate = skip ? S3 : S2;
`else
               nstate = S2;
`endif
            end
         end
         S2:      nstate = (count == '0) ? S3 : S2;
         S3:      nstate = bus.s ? S3 : S1;
         default: nstate = S1;
      endcase
   end

   long_multiplier_acc u_acc (
      .Clock(Clock), .Resetn(Resetn),
      .ld(idle), .step(busy),
      .hi(hi), .lo(lo), .b(b),
      .p(bus.P)
   );

   assign bus.Done = (state == S3);

endmodule

// File: tb/tb_long_multiplier.sv
// tb_long_multiplier: directed vectors against an arithmetic model.
// Model: P = A*B + C, Done after n+1 edges (1 on zero skip).
module tb_long_multiplier;
   import long_multiplier_pkg::*;

   logic Clock = 1'b0;
   logic Resetn;

   long_multiplier_if bus();

   long_multiplier dut (
      .Clock(Clock),
      .Resetn(Resetn),
      .bus(bus)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   bit          mdl_run = 1'b0;
   int          mdl_cnt = 0;
   int          mdl_lat = N + 1;
   logic [15:0] mdl_p   = '0;

   logic [15:0] r;
   int          l;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic int lat_of(logic [7:0] a, logic [7:0] b);
`ifdef LONG_MULTIPLIER_ZERO_SKIP_EN
      if (a == 0 || b == 0) return 1;
`endif
      return N + 1;
   endfunction

   // edges seen since the start request was first sampled
   always @(posedge Clock) if (mdl_run) mdl_cnt++;

   // compare DUT against the model whenever an operation is live
   always @(negedge Clock) begin
      if (mdl_run) begin
         chk("done_timing", 32'(bus.Done), 32'(mdl_cnt >= mdl_lat));
         if (mdl_cnt >= mdl_lat)
            chk("p_model", 32'(bus.P), 32'(mdl_p));
      end
   end

   task automatic load_ops(logic [7:0] a, logic [7:0] b, logic [7:0] c);
      @(negedge Clock); #1;
      bus.DataA = a; bus.DataB = b; bus.DataC = c;
      bus.LA = 1; bus.EB = 1; bus.EC = 1; bus.s = 0;
      @(negedge Clock); #1;
      bus.LA = 0; bus.EB = 0; bus.EC = 0;
      mdl_p   = 16'(int'(a) * int'(b) + int'(c));
      mdl_lat = lat_of(a, b);
      mdl_cnt = 0;
      mdl_run = 1;
      bus.s   = 1;
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input int hold,
                         input bit pulse,
                         output logic [15:0] res, output int lat);
      load_ops(a, b, c);
      lat = 0;
      for (int i = 0; i < 20 && !bus.Done; i++) begin
         @(posedge Clock); #1;
         lat++;
         if (pulse && lat == 3) begin
            bus.LA = 1; bus.DataA = 8'd99;
         end
         if (lat == 4) bus.LA = 0;
      end
      bus.LA = 0;
      chk("done_seen", 32'(bus.Done), 32'd1);
      res = bus.P;
      repeat (hold) @(posedge Clock);
      @(negedge Clock); #1;
      bus.s = 0;
      @(posedge Clock);
      mdl_run = 0;
      #1;
      chk("done_fall", 32'(bus.Done), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Resetn = 0;
      bus.s = 0; bus.LA = 0; bus.EB = 0; bus.EC = 0;
      bus.DataA = '0; bus.DataB = '0; bus.DataC = '0;
      #12;
      chk("reset_p", 32'(bus.P), 32'd0);
      chk("reset_done", 32'(bus.Done), 32'd0);
      @(negedge Clock);
      Resetn = 1;

      run_op(8'd13, 8'd11, 8'd0, 3, 1'b0, r, l);
      chk("p_13x11", 32'(r), 32'd143);
      chk("lat_13x11", 32'(l), 32'd9);

      run_op(8'd255, 8'd255, 8'd255, 0, 1'b0, r, l);
      chk("p_max", 32'(r), 32'd65280);
      chk("lat_max", 32'(l), 32'd9);

      run_op(8'd23, 8'd7, 8'd2, 0, 1'b0, r, l);
      chk("p_divinv", 32'(r), 32'd163);

      run_op(8'd0, 8'd200, 8'd7, 1, 1'b0, r, l);
      chk("p_zero_a", 32'(r), 32'd7);
`ifdef LONG_MULTIPLIER_ZERO_SKIP_EN
      chk("lat_zero_a", 32'(l), 32'd1);
`else
      chk("lat_zero_a", 32'(l), 32'd9);
`endif

      run_op(8'd13, 8'd11, 8'd0, 2, 1'b1, r, l);
      chk("p_la_pulse", 32'(r), 32'd143);

      run_op(8'd255, 8'd1, 8'd0, 0, 1'b0, r, l);
      chk("p_255x1", 32'(r), 32'd255);

      load_ops(8'd200, 8'd3, 8'd5);
      repeat (5) @(posedge Clock);
      #1;
      Resetn  = 0;
      bus.s   = 0;
      mdl_run = 0;
      #1;
      chk("abort_p", 32'(bus.P), 32'd0);
      chk("abort_done", 32'(bus.Done), 32'd0);
      @(negedge Clock); #1;
      Resetn = 1;

      run_op(8'd6, 8'd9, 8'd1, 0, 1'b0, r, l);
      chk("p_after_reset", 32'(r), 32'd55);
      chk("lat_after_reset", 32'(l), 32'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
